idu_queue: RTL

IDU_QUEUE -- requirements
Module: idu_queue

---
 rtl/idu_queue.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/idu_queue.sv
// Instruction decode queue: DEPTH-entry FIFO feeding a one-entry decoded output stage, with a RUN/WFI halt FSM.
// Optional direct-to-stage bypass for an empty queue is enabled by defining IDU_QUEUE_BYPASS_EN.
`ifndef OP_RNG
`define OP_RNG 6:0
`endif
`ifndef LD_OP_CODE
`define LD_OP_CODE 7'h01
`endif
`ifndef ST_OP_CODE
`define ST_OP_CODE 7'h02
`endif
`ifndef STM_OP_CODE
`define STM_OP_CODE 7'h03
`endif
`ifndef MM_OP_CODE
`define MM_OP_CODE 7'h04
`endif
`ifndef ACT_OP_CODE
`define ACT_OP_CODE 7'h05
`endif
`ifndef POOL_OP_CODE
`define POOL_OP_CODE 7'h06
`endif
`ifndef WFI_OP_CODE
`define WFI_OP_CODE 7'h07
`endif

module idu_queue #(
  parameter int INS_W = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ifu_idu_vld,
  input  logic [INS_W-1:0]         ifu_idu_ins,
  output logic                     idu_ifu_rdy,
  output logic                     idu_ifu_wfi,
  input  logic                     idu_wake,
  input  logic                     lsu_idu_rdy,
  input  logic                     mxu_idu_rdy,
  output logic                     idu_lsu_vld,
  output logic [6:0]               idu_lsu_op,
  output logic [INS_W-1:0]         idu_lsu_ins,
  output logic [$clog2(DEPTH):0]   idu_cnt,
  output logic                     idu_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {RUN, WFI} state_t;

  state_t            r_state, w_state_next;
  logic [INS_W-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_cnt;
  logic              r_vld;
  logic [6:0]        r_op;
  logic [INS_W-1:0]  r_ins;
  logic              r_err;

  logic              w_rdy, w_issue, w_enq, w_load_ok, w_deq, w_byp, w_push, w_load;
  logic [INS_W-1:0]  w_load_ins;
  logic [6:0]        w_load_op;

  function automatic logic [6:0] f_decode(input logic [6:0] opc);
    logic [6:0] op;
    op = '0;
    case (opc)
      `LD_OP_CODE:   op = 7'b0000001;
      `ST_OP_CODE:   op = 7'b0000010;
      `STM_OP_CODE:  op = 7'b0000100;
      `MM_OP_CODE:   op = 7'b0001000;
      `ACT_OP_CODE:  op = 7'b0010000;
      `POOL_OP_CODE: op = 7'b0100000;
      `WFI_OP_CODE:  op = 7'b1000000;
      default:       op = '0;
    endcase
    return op;
  endfunction

  assign w_rdy   = (r_cnt != FULL_CNT);
  assign w_issue = r_vld & lsu_idu_rdy & (~r_op[3] | mxu_idu_rdy);
  assign w_enq   = ifu_idu_vld & w_rdy;
  // A WFI leaving the stage must not pull in its successor on the same edge.
  assign w_load_ok = (r_state == RUN) & ~(w_issue & r_op[6]) & (~r_vld | w_issue);
  assign w_deq     = w_load_ok & (r_cnt != '0);
`ifdef IDU_QUEUE_BYPASS_EN
  assign w_byp     = w_load_ok & (r_cnt == '0) & w_enq;
`else
  assign w_byp     = 1'b0;
`endif
  assign w_push     = w_enq & ~w_byp;
  assign w_load     = w_deq | w_byp;
  assign w_load_ins = w_byp ? ifu_idu_ins : r_mem[r_rptr];
  assign w_load_op  = f_decode(w_load_ins[`OP_RNG]);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_issue & r_op[6]) w_state_next = WFI;
      WFI:     if (idu_wake) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_op    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_deq)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_deq);
      if (w_load) begin
        r_vld <= |w_load_op;
        r_op  <= w_load_op;
        if (w_load_op == '0) r_err <= 1'b1;
      end else if (w_issue) begin
        r_vld <= 1'b0;
        r_op  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= ifu_idu_ins;
    if (w_load && (w_load_op != '0)) r_ins <= w_load_ins;
  end

  assign idu_ifu_rdy = w_rdy;
  assign idu_ifu_wfi = (r_state == WFI);
  assign idu_lsu_vld = r_vld;
  assign idu_lsu_op  = r_op;
  assign idu_lsu_ins = r_ins;
  assign idu_cnt     = r_cnt;
  assign idu_err     = r_err;
endmodule
